// File: rtl/path_check_pkg.sv
// Shared types and constants for the PRBS7 data-path checker.
// Holds the checker FSM encoding, PRBS7 seed/taps and the LFSR step function.
package path_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam logic [6:0] PRBS_SEED   = 7'h7F;
  localparam int         PRBS_TAP_HI = 6;
  localparam int         PRBS_TAP_LO = 5;

  // One step of the x^7+x^6+1 Fibonacci LFSR, feedback entering at bit 0.
  function automatic logic [6:0] prbs7_next(input logic [6:0] cur);
    return {cur[5:0], cur[PRBS_TAP_HI] ^ cur[PRBS_TAP_LO]};
  endfunction

endpackage

// File: rtl/prbs7_gen.sv
// PRBS7 stimulus source: LFSR advances only while enabled, output bit registered.
module prbs7_gen
  import path_check_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic prbs_bit
);

  logic [6:0] lfsr_r;

  // LFSR state and registered stimulus bit
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r   <= PRBS_SEED;
      prbs_bit <= 1'b0;
    end else begin
      if (en) begin
        lfsr_r <= prbs7_next(lfsr_r);
      end else begin
        lfsr_r <= lfsr_r;
      end
      prbs_bit <= lfsr_r[PRBS_TAP_HI];
    end
  end

endmodule

// File: rtl/path_checker.sv
// Drives a PRBS7 pattern into a fixed-latency data path and counts mismatches
// between its output and a locally delayed copy of the stimulus.
module path_checker
  import path_check_pkg::*;
#(
  parameter int DATA_DEPTH = 10,
  parameter int ERR_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr_err,
  output logic                 stim,
  input  logic                 dp_out,
  output logic                 locked,
  output logic                 err_flag,
  output logic [ERR_WIDTH-1:0] err_cnt
);

  localparam int                   FILL_W    = $clog2(DATA_DEPTH + 1);
  localparam logic [FILL_W-1:0]    FILL_LOAD = FILL_W'(DATA_DEPTH);
  localparam logic [FILL_W-1:0]    FILL_ONE  = FILL_W'(1);
  localparam logic [ERR_WIDTH-1:0] ERR_MAX   = {ERR_WIDTH{1'b1}};
  localparam logic [ERR_WIDTH-1:0] ERR_ONE   = ERR_WIDTH'(1);

  state_t                state_r;
  state_t                state_next_s;
  logic [FILL_W-1:0]     fill_cnt_r;
  logic [FILL_W-1:0]     fill_cnt_next_s;
  logic [DATA_DEPTH-1:0] exp_line_r;
  logic                  mismatch_s;

  prbs7_gen u_prbs (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .prbs_bit (stim)
  );

  // Expected-data line mirrors the free-running data path registers
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_line_r <= '0;
    end else begin
      exp_line_r[0] <= stim;
      for (int i = 1; i < DATA_DEPTH; i++) begin
        exp_line_r[i] <= exp_line_r[i-1];
      end
    end
  end

  assign mismatch_s = dp_out ^ exp_line_r[DATA_DEPTH-1];

  // Next-state logic: FILL waits out the path latency before checking starts
  always_comb begin
    state_next_s    = state_r;
    fill_cnt_next_s = fill_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (en) begin
          state_next_s    = ST_FILL;
          fill_cnt_next_s = FILL_LOAD;
        end else begin
          state_next_s    = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (!en) begin
          state_next_s    = ST_IDLE;
        end else begin
          fill_cnt_next_s = fill_cnt_r - FILL_ONE;
          if (fill_cnt_r == FILL_ONE) begin
            state_next_s  = ST_CHECK;
          end else begin
            state_next_s  = ST_FILL;
          end
        end
      end
      ST_CHECK: begin
        if (!en) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_CHECK;
        end
      end
      default: begin
        state_next_s    = ST_IDLE;
        fill_cnt_next_s = '0;
      end
    endcase
  end

  // State, fill counter and lock indication registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      fill_cnt_r <= '0;
      locked     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      fill_cnt_r <= fill_cnt_next_s;
      locked     <= (state_next_s == ST_CHECK);
    end
  end

  // Sticky error flag and saturating counter; clear wins over a same-cycle mismatch
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (clr_err) begin
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else if ((state_r == ST_CHECK) && mismatch_s) begin
      err_flag <= 1'b1;
      if (err_cnt != ERR_MAX) begin
        err_cnt <= err_cnt + ERR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_path_checker.sv
// Bench for path_checker: ideal 10-cycle data path, reference model of the
// checker behaviour compared every cycle, plus directed literal checks.
module tb_path_checker;

  localparam int D = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        clr_err = 1'b0;
  logic [1:0]  inj = 2'b00;
  logic        stim0, stim1, locked0, locked1, flag0, flag1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;
  logic [D-1:0] dl0 = '0;
  logic [D-1:0] dl1 = '0;
  logic        dp0, dp1;
  logic        s_rst = 1'b0;
  logic        s_en = 1'b0;
  logic        s_clr = 1'b0;
  logic [1:0]  s_dp = 2'b00;
  logic [7:0]  first8 = 8'b0111_1111;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  assign dp0 = dl0[D-1] ^ inj[0];
  assign dp1 = dl1[D-1] ^ inj[1];

  path_checker #(.DATA_DEPTH(D), .ERR_WIDTH(16)) dut0 (
    .clk(clk), .rst(rst), .en(en), .clr_err(clr_err), .stim(stim0),
    .dp_out(dp0), .locked(locked0), .err_flag(flag0), .err_cnt(cnt0)
  );

  path_checker #(.DATA_DEPTH(D), .ERR_WIDTH(4)) dut1 (
    .clk(clk), .rst(rst), .en(en), .clr_err(clr_err), .stim(stim1),
    .dp_out(dp1), .locked(locked1), .err_flag(flag1), .err_cnt(cnt1)
  );

  // Ideal data paths: pure D-cycle delay of each DUT's stimulus
  always @(posedge clk) begin
    dl0 <= {dl0[D-2:0], stim0};
    dl1 <= {dl1[D-2:0], stim1};
  end

  // Inputs as seen by the DUTs at each rising edge, for the model
  always @(posedge clk) begin
    s_rst <= rst;
    s_en  <= en;
    s_clr <= clr_err;
    s_dp  <= {dp1, dp0};
  end

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: PRBS sequence from its recurrence, lock from the run of en
  initial begin : model
    bit seq[127];
    bit mh[D+1];
    int k;
    int run;
    bit m_stim;
    bit m_locked;
    bit prev_locked;
    bit m_live;
    bit mm;
    int m_cnt[2];
    bit m_flag[2];
    int m_max[2];
    for (int n = 0; n < 7; n++) seq[n] = 1'b1;
    for (int n = 7; n < 127; n++) seq[n] = seq[n-7] ^ seq[n-6];
    m_max[0] = 65535;
    m_max[1] = 15;
    m_live = 1'b0;
    k = 0; run = 0; m_stim = 1'b0; m_locked = 1'b0;
    for (int i = 0; i < 2; i++) begin m_cnt[i] = 0; m_flag[i] = 1'b0; end
    for (int j = 0; j <= D; j++) mh[j] = 1'b0;
    forever begin
      @(negedge clk);
      if (s_rst) begin
        m_live = 1'b1;
        k = 0; run = 0; m_stim = 1'b0; m_locked = 1'b0;
        for (int i = 0; i < 2; i++) begin m_cnt[i] = 0; m_flag[i] = 1'b0; end
        for (int j = 0; j <= D; j++) mh[j] = 1'b0;
      end else if (m_live) begin
        prev_locked = m_locked;
        for (int i = 0; i < 2; i++) begin
          mm = (s_dp[i] != mh[D]);
          if (s_clr) begin
            m_cnt[i] = 0;
            m_flag[i] = 1'b0;
          end else if (prev_locked && mm) begin
            m_flag[i] = 1'b1;
            if (m_cnt[i] < m_max[i]) m_cnt[i] = m_cnt[i] + 1;
          end
        end
        m_stim = seq[k];
        if (s_en) k = (k + 1) % 127;
        for (int j = D; j > 0; j--) mh[j] = mh[j-1];
        mh[0] = m_stim;
        run = s_en ? ((run < 100000) ? run + 1 : run) : 0;
        m_locked = (run >= D + 1);
      end
      if (m_live) begin
        chk("cyc_stim0", stim0, m_stim);
        chk("cyc_stim1", stim1, m_stim);
        chk("cyc_locked0", locked0, m_locked);
        chk("cyc_locked1", locked1, m_locked);
        chk("cyc_cnt0", cnt0, m_cnt[0]);
        chk("cyc_cnt1", cnt1, m_cnt[1]);
        chk("cyc_flag0", flag0, m_flag[0]);
        chk("cyc_flag1", flag1, m_flag[1]);
      end
    end
  end

  // Directed stimulus with hand-computed expectations
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_stim", stim0, 0);
    chk("rst_locked", locked0, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_flag0", flag0, 0);
    chk("rst_cnt1", cnt1, 0);

    rst = 1'b0;
    en  = 1'b1;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c < 8) chk("prbs_first8", stim0, first8[c]);
      if (c == 9) chk("locked_early", locked0, 0);
      if (c == 10) chk("locked_after_fill", locked0, 1);
    end

    repeat (1000) @(negedge clk);
    chk("clean_cnt0", cnt0, 0);
    chk("clean_flag0", flag0, 0);
    chk("clean_cnt1", cnt1, 0);
    chk("clean_flag1", flag1, 0);

    inj[0] = 1'b1;
    @(negedge clk);
    chk("single_cnt", cnt0, 1);
    chk("single_flag", flag0, 1);
    inj[0] = 1'b0;
    repeat (20) @(negedge clk);
    chk("single_no_more", cnt0, 1);

    inj[1] = 1'b1;
    repeat (14) @(negedge clk);
    chk("sat_14", cnt1, 14);
    @(negedge clk);
    chk("sat_15", cnt1, 15);
    repeat (10) @(negedge clk);
    chk("sat_hold", cnt1, 15);
    chk("sat_flag", flag1, 1);
    chk("sat_other_inst", cnt0, 1);
    inj[1] = 1'b0;
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("clr_cnt0", cnt0, 0);
    chk("clr_cnt1", cnt1, 0);
    chk("clr_flag1", flag1, 0);

    inj[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_clr_cnt", cnt0, 3);
    clr_err = 1'b1;
    @(negedge clk);
    chk("clr_prio_cnt", cnt0, 0);
    chk("clr_prio_flag", flag0, 0);
    clr_err = 1'b0;
    inj[0] = 1'b0;

    inj[0] = 1'b1;
    repeat (5) @(negedge clk);
    inj[0] = 1'b0;
    chk("five_errs", cnt0, 5);
    en = 1'b0;
    @(negedge clk);
    chk("en_drop_locked", locked0, 0);
    chk("en_drop_cnt", cnt0, 5);
    repeat (2) @(negedge clk);
    en = 1'b1;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c == 9) chk("relock_early", locked0, 0);
      if (c == 10) chk("relock", locked0, 1);
    end
    chk("relock_cnt", cnt0, 5);
    chk("relock_flag", flag0, 1);

    rst = 1'b1;
    @(negedge clk);
    chk("midrst_stim", stim0, 0);
    chk("midrst_locked", locked0, 0);
    chk("midrst_cnt0", cnt0, 0);
    chk("midrst_flag0", flag0, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    inj[0] = 1'b1;
    repeat (3) @(negedge clk);
    inj[0] = 1'b0;
    chk("fill_locked", locked0, 0);
    chk("fill_ignored_cnt", cnt0, 0);
    repeat (20) @(negedge clk);
    chk("post_rst_locked", locked0, 1);
    chk("post_rst_cnt", cnt0, 0);
    chk("post_rst_flag", flag0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/path_checker.md
PATH_CHECKER -- requirements
Module: path_checker

Interface
REQ-001 SHALL have parameter DATA_DEPTH, default 10, meaning register stages in the checked data path (its latency in cycles), legal range 1..1024.
REQ-002 SHALL have parameter ERR_WIDTH, default 16, meaning error counter width, legal range 2..32.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port en  input  1  run enable: generate stimulus and check while high.
REQ-006 SHALL have port clr_err  input  1  one-cycle pulse that clears err_cnt and err_flag.
REQ-007 SHALL have port stim  output  1  PRBS stimulus bit driving the data path input.
REQ-008 SHALL have port dp_out  input  1  data path output bit to be checked.
REQ-009 SHALL have port locked  output  1  high while in CHECK.
REQ-010 SHALL have port err_flag  output  1  sticky: at least one mismatch since the last clear.
REQ-011 SHALL have port err_cnt  output  ERR_WIDTH  saturating mismatch count.

Function
REQ-012 SHALL generate PRBS7 (x^7+x^6+1): when en=1, next = {lfsr[5:0], lfsr[6]^lfsr[5]}; lfsr holds when en=0; stim = lfsr[6], registered.
REQ-013 SHALL give a PRBS period of 127 from seed 7'h7F: first 7 stim bits are 1 and the 8th is 0.
REQ-014 SHALL keep a DATA_DEPTH-deep expected-data shift line that shifts stim every cycle regardless of en, matching the data path's free-running registers.
REQ-015 SHALL compare dp_out against the shift-line output (stim delayed exactly DATA_DEPTH cycles) every cycle.
REQ-016 SHALL implement FSM states IDLE, FILL and CHECK.
REQ-017 IDLE: on en=1, go to FILL and load fill counter with DATA_DEPTH.
REQ-018 FILL: decrement the fill counter each cycle; at 1 with en=1, go to CHECK (first compare is DATA_DEPTH cycles after leaving IDLE).
REQ-019 In any state, en=0 SHALL force IDLE on the next edge; locked falls in the same cycle the state leaves CHECK.
REQ-020 Mismatches SHALL be counted only in CHECK; they are ignored in IDLE and FILL.
REQ-021 Each CHECK-state mismatch SHALL increment err_cnt by 1, saturating at 2^ERR_WIDTH-1 with no wrap, and SHALL set err_flag.
REQ-022 clr_err SHALL zero err_cnt and err_flag on the next edge and take priority over a simultaneous mismatch (result 0, flag 0).
REQ-023 err_cnt and err_flag SHALL be retained across IDLE/FILL transitions; only clr_err or rst clears them.
REQ-024 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-025 On rst=1 at a clock edge: state=IDLE, lfsr=7'h7F, stim=0, shift line all 0, fill counter=0, locked=0, err_flag=0, err_cnt=0.
REQ-026 rst SHALL take priority over en and clr_err; reset mid-CHECK returns to IDLE and re-runs FILL before checking resumes.

Structure
REQ-027 Package path_check_pkg SHALL hold the FSM state enum, PRBS7 seed 7'h7F and tap positions 6/5.
REQ-028 The PRBS generator SHALL be a sub-module, prbs7_gen (clk, rst, en, bit out).
REQ-029 Fill counter width SHALL be $clog2(DATA_DEPTH+1).

Verification (bench models the data path as an ideal DATA_DEPTH-cycle delay, DATA_DEPTH=10)
REQ-030 Reset, then en=1 -> first 8 stim bits 1,1,1,1,1,1,1,0; locked rises after exactly 10 FILL cycles; after 1000 cycles err_cnt=0, err_flag=0.
REQ-031 Invert dp_out for one cycle during CHECK -> err_cnt=1 and err_flag=1 on the following edge; nothing further counted.
REQ-032 ERR_WIDTH=4, dp_out permanently inverted during CHECK -> err_cnt reaches 15 after 15 cycles and holds at 15.
REQ-033 clr_err pulsed in the same cycle as an injected mismatch -> err_cnt=0 and err_flag=0 next cycle.
REQ-034 en dropped for 3 cycles mid-CHECK with err_cnt=5 -> locked=0 next cycle, err_cnt stays 5; after en returns, locked rises again after 10 cycles.
REQ-035 rst pulsed mid-CHECK -> all outputs at reset values next cycle; a mismatch injected during the following FILL is not counted.
